// File: rtl/signed_div_issue_queue.sv
// Request FIFO and start/done sequencer in front of the 32-bit signed iterative divider.
// Optional DIV_SPECIAL_CASE_EN answers divide-by-zero and 0x80000000/-1 locally without starting the divider.
module signed_div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_dividend,
    input  logic [31:0]                  req_divisor,
    input  logic [TAG_W-1:0]             req_tag,
    output logic                         div_start,
    output logic [31:0]                  div_dividend,
    output logic [31:0]                  div_divisor,
    input  logic                         div_done,
    input  logic [31:0]                  div_quotient,
    input  logic [31:0]                  div_remainder,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_quotient,
    output logic [31:0]                  rsp_remainder,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_dz,
    output logic                         rsp_ovf,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_next;

    logic [31:0]      fifo_dvd [DEPTH];
    logic [31:0]      fifo_dvs [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic [31:0]      head_dvd, head_dvs;
    logic [TAG_W-1:0] head_tag;
    logic             head_dz, head_ovf, head_special;
    logic             push, pop;

    logic [TAG_W-1:0] op_tag;
    logic             op_dz, op_ovf;

    assign req_ready = (count < DEPTH_C);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);

    assign head_dvd = fifo_dvd[rd_ptr];
    assign head_dvs = fifo_dvs[rd_ptr];
    assign head_tag = fifo_tag[rd_ptr];
    assign head_dz  = (head_dvs == 32'h0);
    assign head_ovf = (head_dvd == 32'h8000_0000) && (head_dvs == 32'hFFFF_FFFF);

`ifdef DIV_SPECIAL_CASE_EN
    assign head_special = head_dz || head_ovf;
`else
    assign head_special = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dvd[wr_ptr] <= req_dividend;
            fifo_dvs[wr_ptr] <= req_divisor;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = head_special ? HOLD : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_done) state_next = HOLD;
            HOLD:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign div_start = (state == ISSUE);
    assign rsp_valid = (state == HOLD);
    assign busy      = (count != '0) || (state != IDLE);

    // Operand holding register stays put from ISSUE through completion; the divider re-reads it at done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            op_tag       <= '0;
            op_dz        <= 1'b0;
            op_ovf       <= 1'b0;
        end else if (pop) begin
            div_dividend <= head_dvd;
            div_divisor  <= head_dvs;
            op_tag       <= head_tag;
            op_dz        <= head_dz;
            op_ovf       <= head_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_tag       <= '0;
            rsp_dz        <= 1'b0;
            rsp_ovf       <= 1'b0;
        end else if (pop && head_special) begin
            rsp_quotient  <= head_ovf ? 32'h8000_0000 : 32'hFFFF_FFFF;
            rsp_remainder <= head_ovf ? 32'h0 : head_dvd;
            rsp_tag       <= head_tag;
            rsp_dz        <= head_dz;
            rsp_ovf       <= head_ovf;
        end else if ((state == WAIT) && div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_tag       <= op_tag;
            rsp_dz        <= op_dz;
            rsp_ovf       <= op_ovf;
        end
    end
endmodule

// File: tb/tb_signed_div_issue_queue.sv
// Randomized self-checking bench for signed_div_issue_queue with a behavioural divider and a queue-based reference model.
// Build with DIV_SPECIAL_CASE_EN defined to check the local special-case path timing.
module tb_signed_div_issue_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_dividend, req_divisor;
    logic [3:0]  req_tag;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done;
    logic [31:0] div_quotient, div_remainder;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic [3:0]  rsp_tag;
    logic        rsp_dz, rsp_ovf, busy;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    signed_div_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_tag(rsp_tag),
        .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t ref_result(logic [31:0] a, logic [31:0] b, logic [3:0] t);
        exp_t e;
        int sa, sb;
        e.tag = t;
        e.dz  = (b == 32'd0);
        e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (e.dz) begin
            e.q = 32'hFFFF_FFFF; e.r = a;
        end else if (e.ovf) begin
            e.q = 32'h8000_0000; e.r = 32'd0;
        end else begin
            sa = a; sb = b;
            e.q = sa / sb; e.r = sa % sb;
        end
        return e;
    endfunction

    // Behavioural divider: random latency, done is a level held until the next start.
    int div_cnt;
    logic div_active;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done <= 1'b0; div_active <= 1'b0; div_cnt <= 0;
            div_quotient <= '0; div_remainder <= '0;
        end else if (div_start) begin
            div_done <= 1'b0; div_active <= 1'b1;
            div_cnt <= int'($urandom_range(34, 40));
        end else if (div_active) begin
            if (div_cnt == 1) begin
                exp_t d;
                d = ref_result(div_dividend, div_divisor, 4'd0);
                div_quotient <= d.q; div_remainder <= d.r;
                div_done <= 1'b1; div_active <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    int start_cnt = 0;
    int max_cnt   = 0;
    always @(posedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (int'(count) > max_cnt) max_cnt <= int'(count);
    end

    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, output bit ok);
        int n = 0;
        ok = 1'b0;
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_tag = t;
        while (!req_ready && n < 2000) begin @(posedge clk); #1; n++; end
        if (req_ready) begin
            exp_q.push_back(ref_result(a, b, t));
            @(posedge clk); #1;
            ok = 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output exp_t o, output bit ok);
        int n = 0;
        ok = 1'b0;
        o = '{default: '0};
        rsp_ready = 1'b0;
        while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) return;
        repeat (hold) begin @(posedge clk); #1; end
        o.q = rsp_quotient; o.r = rsp_remainder; o.tag = rsp_tag; o.dz = rsp_dz; o.ovf = rsp_ovf;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        total++;
        if ({rsp_valid, req_ready, count, busy, div_start} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_ctrl got v=%b rdy=%b cnt=%0d busy=%b st=%b exp 0 1 0 0 0",
                     rsp_valid, req_ready, count, busy, div_start);
        end
        total++;
        if ({div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_tag, rsp_dz, rsp_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_data got dvd=%h dvs=%h q=%h r=%h exp all zero",
                     div_dividend, div_divisor, rsp_quotient, rsp_remainder);
        end
    endtask

    task automatic test_basic();
        bit ok; exp_t o, e; int s0, n;
        s0 = start_cnt;
        push_req(32'd100, 32'd7, 4'd3, ok);
        total++;
        if (!ok || count !== 3'd1 || div_start !== 1'b0) begin
            bad++; $display("FAIL basic_push ok=%b cnt=%0d start=%b exp 1 1 0", ok, count, div_start);
        end
        @(posedge clk); #1;
        total++;
        if (div_start !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL basic_start got start=%b cnt=%0d exp 1 0", div_start, count);
        end
        @(posedge clk); #1;
        total++;
        if (div_start !== 1'b0 || busy !== 1'b1 || div_dividend !== 32'd100 || div_divisor !== 32'd7) begin
            bad++; $display("FAIL basic_wait got start=%b busy=%b dvd=%h dvs=%h", div_start, busy, div_dividend, div_divisor);
        end
        n = 0;
        while (!div_done && n < 200) begin @(posedge clk); #1; n++; end
        total++;
        if (div_done !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL basic_done got done=%b valid=%b exp 1 0", div_done, rsp_valid);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL basic_rsp_lat got valid=%b exp 1", rsp_valid);
        end
        get_rsp(3, o, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {o.q, o.r, o.tag, o.dz, o.ovf} !== {e.q, e.r, e.tag, e.dz, e.ovf} || o.q !== 32'd14) begin
            bad++; $display("FAIL basic_result got q=%h r=%h tag=%h dz=%b ovf=%b exp q=%h r=%h tag=%h",
                            o.q, o.r, o.tag, o.dz, o.ovf, e.q, e.r, e.tag);
        end
        total++;
        if (start_cnt - s0 !== 1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL basic_starts got %0d valid=%b exp 1 0", start_cnt - s0, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; exp_t o, e;
        push_req(-32'sd100, 32'd7, 4'd1, ok);
        push_req(32'd100, -32'sd7, 4'd2, ok);
        for (int i = 0; i < 2; i++) begin
            get_rsp(0, o, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || {o.q, o.r, o.tag, o.dz, o.ovf} !== {e.q, e.r, e.tag, e.dz, e.ovf}) begin
                bad++; $display("FAIL b2b_%0d got q=%h r=%h tag=%h exp q=%h r=%h tag=%h", i, o.q, o.r, o.tag, e.q, e.r, e.tag);
            end
        end
    endtask

    task automatic test_full();
        bit ok; bit ok6;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_req(32'd1000 + i, 32'd3, 4'(i), ok);
        total++;
        if (req_ready !== 1'b0 || count !== 3'd4) begin
            bad++; $display("FAIL full_stall got rdy=%b cnt=%0d exp 0 4", req_ready, count);
        end
        fork
            push_req(32'd1005, 32'd3, 4'd5, ok6);
            begin
                exp_t o, e;
                for (int i = 0; i < 6; i++) begin
                    get_rsp(0, o, ok);
                    e = exp_q.pop_front();
                    total++;
                    if (!ok || {o.q, o.r, o.tag} !== {e.q, e.r, e.tag}) begin
                        bad++; $display("FAIL full_order_%0d got q=%h tag=%h exp q=%h tag=%h", i, o.q, o.tag, e.q, e.tag);
                    end
                end
            end
        join
        total++;
        if (!ok6 || max_cnt > 4 || busy !== 1'b0) begin
            bad++; $display("FAIL full_bound got ok6=%b maxcnt=%0d busy=%b exp 1 <=4 0", ok6, max_cnt, busy);
        end
    endtask

    task automatic test_special();
        bit ok; exp_t o, e; int s0;
        s0 = start_cnt;
        push_req(32'd5, 32'd0, 4'd9, ok);
`ifdef DIV_SPECIAL_CASE_EN
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL dz_early got valid=%b exp 0", rsp_valid); end
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL dz_latency got valid=%b exp 1", rsp_valid); end
`endif
        get_rsp(1, o, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {o.q, o.r, o.tag, o.dz, o.ovf} !== {e.q, e.r, e.tag, e.dz, e.ovf}) begin
            bad++; $display("FAIL dz_result got q=%h r=%h dz=%b ovf=%b exp q=%h r=%h dz=%b", o.q, o.r, o.dz, o.ovf, e.q, e.r, e.dz);
        end
        push_req(32'h8000_0000, 32'hFFFF_FFFF, 4'd10, ok);
        get_rsp(0, o, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {o.q, o.r, o.tag, o.dz, o.ovf} !== {e.q, e.r, e.tag, e.dz, e.ovf}) begin
            bad++; $display("FAIL ovf_result got q=%h r=%h dz=%b ovf=%b exp q=%h r=%h ovf=%b", o.q, o.r, o.dz, o.ovf, e.q, e.r, e.ovf);
        end
        total++;
`ifdef DIV_SPECIAL_CASE_EN
        if (start_cnt - s0 !== 0) begin bad++; $display("FAIL special_starts got %0d exp 0", start_cnt - s0); end
`else
        if (start_cnt - s0 !== 2) begin bad++; $display("FAIL special_starts got %0d exp 2", start_cnt - s0); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok; bit stale; exp_t o, e;
        push_req(32'd50, 32'd7, 4'd4, ok);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if ({rsp_valid, req_ready, count, busy, div_start, div_dividend} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0}) begin
            bad++; $display("FAIL rst_mid got v=%b rdy=%b cnt=%0d busy=%b dvd=%h", rsp_valid, req_ready, count, busy, div_dividend);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        stale = 1'b0;
        repeat (60) begin @(posedge clk); #1; if (rsp_valid || busy) stale = 1'b1; end
        total++;
        if (stale) begin bad++; $display("FAIL rst_stale got stale response/busy=1 exp 0"); end
        push_req(32'd9, 32'd3, 4'd6, ok);
        get_rsp(0, o, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {o.q, o.r, o.tag} !== {32'd3, 32'd0, 4'd6} || {o.q, o.r} !== {e.q, e.r}) begin
            bad++; $display("FAIL rst_after got q=%h r=%h tag=%h exp 3 0 6", o.q, o.r, o.tag);
        end
    endtask

    task automatic test_random();
        localparam int N = 24;
        fork
            begin
                bit ok;
                logic [31:0] a, b;
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 9))
                        0: begin a = $urandom; b = 32'd0; end
                        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                        2: begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))) | 32'd1; end
                        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 28); end
                    endcase
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    push_req(a, b, 4'(i), ok);
                end
            end
            begin
                bit ok;
                exp_t o, e;
                for (int i = 0; i < N; i++) begin
                    get_rsp(int'($urandom_range(0, 3)), o, ok);
                    total++;
                    if (!ok || exp_q.size() == 0) begin
                        bad++; $display("FAIL rand_%0d got ok=%b pending=%0d exp response", i, ok, exp_q.size());
                    end else begin
                        e = exp_q.pop_front();
                        if ({o.q, o.r, o.tag, o.dz, o.ovf} !== {e.q, e.r, e.tag, e.dz, e.ovf}) begin
                            bad++; $display("FAIL rand_%0d got q=%h r=%h tag=%h dz=%b ovf=%b exp q=%h r=%h tag=%h dz=%b ovf=%b",
                                            i, o.q, o.r, o.tag, o.dz, o.ovf, e.q, e.r, e.tag, e.dz, e.ovf);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_full();
        test_special();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
